mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between instruction fetch (IF, read-only) and load/store (LS, read/write).
- Latches one-cycle request pulses, arbitrates, and sequences 1–4 byte transfers as consecutive byte beats.
- Assembles little-endian words and returns a one-cycle done pulse with the data to the owning requester.
- Sits between the PC/fetch unit, the LSU and the external RAM.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, requester data width; fixed at 4 bytes.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- rdy  in  1  global ready; low freezes the block.
- clear  in  1  fetch flush (mispredict); aborts IF work only.
- if_rw_flag  in  2  [0]=read pulse, [1] ignored (IF never writes).
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_len  in  2  byte count minus 1.
- if_busy  out  1  IF request pending or active.
- if_done  out  1  one-cycle read-complete pulse.
- if_rdata  out  DATA_WIDTH  fetched data.
- ls_rw_flag  in  2  [0]=read pulse, [1]=write pulse.
- ls_addr  in  ADDR_WIDTH  load/store byte address.
- ls_len  in  2  byte count minus 1.
- ls_wdata  in  DATA_WIDTH  store data, little-endian.
- ls_busy  out  1  LS request pending or active.
- ls_done  out  1  one-cycle complete pulse (read or write).
- ls_rdata  out  DATA_WIDTH  load data.
- ram_din  in  8  RAM read byte, valid the cycle after its address.
- ram_dout  out  8  RAM write byte.
- ram_a  out  ADDR_WIDTH  RAM byte address.
- ram_wr  out  1  1=write, 0=read.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0; state IDLE; both pending slots empty; last_grant=IF.
- Request capture:
  - A nonzero rw_flag for one cycle is a request. addr, len and wdata are latched into that port's pending slot on the same edge.
  - A second request on a port while its busy=1 is illegal; it is flagged by a simulation assertion and ignored.
  - If both flag bits are set, write wins.
  - busy rises the cycle after capture. It falls in the same cycle as done, or on abort.
- Arbitration (IDLE only):
  - A same-cycle request pulse is eligible for grant immediately (bypass of the pending slot).
  - Fixed priority: LS over IF.
  - A transaction is never preempted once granted.
- FSM states: IDLE, READ, WRITE. Beat counter k is 2 bits.
- READ, granted at edge ending cycle T:
  - Byte k address is on ram_a in cycle T+1+k, with ram_wr=0.
  - ram_din is captured into byte lane k at the end of cycle T+2+k.
  - done and rdata are registered in cycle T+3+len; state returns to IDLE in that cycle.
  - Word read: request in cycle 0 gives done in cycle 6.
- WRITE:
  - Byte k is driven on ram_a/ram_dout with ram_wr=1 in cycle T+1+k.
  - ls_done is high in cycle T+2+len, with ram_wr=0.
  - Word write: done in cycle 5.
- Data rules:
  - Unused upper rdata bytes are 0; sign extension belongs to the LSU.
  - rdata holds its value after done until the next done on that port.
- Address arithmetic: base+k modulo 2^ADDR_WIDTH; 0xFFFFFFFF+1 wraps to 0.
- Back-to-back: a new grant is possible in the cycle done is high, since the FSM is in IDLE then.
- clear:
  - Empties the IF pending slot.
  - If an IF READ is active, the FSM returns to IDLE at the next edge, with no if_done and captured bytes discarded.
  - An IF request pulse coincident with clear is dropped.
  - LS pending and active transfers are unaffected.
- rdy=0:
  - All registers hold and ram_wr is gated to 0 combinationally.
  - The RAM holds its output while rdy=0, so beats resume without re-issue.
  - Request pulses with rdy=0 are not captured.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when both ports are eligible in IDLE, the port not granted last wins. last_grant updates on every grant, which bounds starvation to one transaction.
- Undefined: fixed LS priority; the last_grant register is not instantiated.

Decomposition:
- Shared package (defines.vh): addrWidth/instWidth constants, FSM state encodings, rw_flag bit indices, and the len encoding (0=byte, 1=half, 3=word).
- One natural sub-module, mem_arb_req_slot: per-port pending register (valid, write, addr, len, wdata) with capture, clear and pop. It is instantiated twice.

Test Plan:
- IF word read at 0x1000, RAM bytes 0x13,0x05,0x00,0x00 → ram_a 0x1000..0x1003 in cycles 1..4; if_done in cycle 6 with if_rdata=0x00000513.
- LS byte write to 0x30004 with wdata 0xAB → single ram_wr=1 beat in cycle 1 with ram_dout=0xAB; ls_done in cycle 2.
- IF and LS pulse in the same cycle → LS served first, then IF granted in LS's done cycle. With MEM_ARB_RR_EN and last_grant=LS, IF is served first.
- clear in cycle 3 of an IF word read → no if_done, if_busy=0 next cycle, and a pending LS store starts the following cycle.
- rdy held low in cycles 2–4 of an LS half read from 0xFFFFFFFF → beats frozen, addresses 0xFFFFFFFF then 0x0, done delayed exactly 3 cycles.
- Async reset asserted mid-write → all outputs 0 immediately, including ram_wr; no done pulse afterwards.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM arbiter: widths, FSM codes, flag bits, len codes, lane helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int INST_WIDTH     = 32;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // rw_flag bit positions
  localparam int RW_RD_BIT = 0;
  localparam int RW_WR_BIT = 1;

  // len field is byte count minus one
  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd3;

  // Transaction owner
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Extract little-endian byte lane idx from a word.
  function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  // Replace little-endian byte lane idx of a word.
  function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_req_slot.sv
// One-entry pending request register for a single requester port (valid, write, addr, len, wdata).
// Latency: captured on the edge of the capture strobe, visible the next cycle.
// Backpressure: holds until popped by a grant or emptied by flush; capture is ignored while full.
module mem_arb_req_slot
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap,
  input  logic                  cap_wr,
  input  logic [ADDR_WIDTH-1:0] cap_addr,
  input  logic [1:0]            cap_len,
  input  logic [DATA_WIDTH-1:0] cap_wdata,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  vld,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [1:0]            len,
  output logic [DATA_WIDTH-1:0] wdata
);

  // Flush beats pop beats capture; a full slot never re-captures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld   <= 1'b0;
      wr    <= 1'b0;
      addr  <= '0;
      len   <= LEN_BYTE;
      wdata <= '0;
    end else if (flush || pop) begin
      vld <= 1'b0;
    end else if (cap && !vld) begin
      vld   <= 1'b1;
      wr    <= cap_wr;
      addr  <= cap_addr;
      len   <= cap_len;
      wdata <= cap_wdata;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch (read-only) and load/store; build option MEM_ARB_RR_EN.
// Latency: read done at grant+3+len cycles, write done at grant+2+len; same-cycle requests bypass the pending slot.
// Backpressure: rdy=0 freezes all state and gates ram_wr; one outstanding request per port, signalled by *_busy.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic [1:0]            if_rw_flag,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic [1:0]            if_len,
  output logic                  if_busy,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic [1:0]            ls_rw_flag,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [1:0]            ls_len,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_busy,
  output logic                  ls_done,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr
);

  // Active transaction
  logic [1:0]            state;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] base;
  logic [1:0]            len;
  logic [DATA_WIDTH-1:0] wdata;
  logic [1:0]            k;
  logic                  tail;
  logic [DATA_WIDTH-1:0] rd_buf;

  // Pending slots
  logic                  if_slot_vld, if_slot_wr;
  logic [ADDR_WIDTH-1:0] if_slot_addr;
  logic [1:0]            if_slot_len;
  logic [DATA_WIDTH-1:0] if_slot_wdata;
  logic                  ls_slot_vld, ls_slot_wr;
  logic [ADDR_WIDTH-1:0] ls_slot_addr;
  logic [1:0]            ls_slot_len;
  logic [DATA_WIDTH-1:0] ls_slot_wdata;

  // Request decode and arbitration
  logic                  idle;
  logic                  if_pulse, ls_pulse;
  logic                  if_req, ls_req;
  logic                  grant_ls, grant_if, grant_go;
  logic                  if_cap, ls_cap, if_pop, ls_pop, if_flush;
  logic                  if_eff_wr, ls_eff_wr, sel_wr;
  logic [ADDR_WIDTH-1:0] if_eff_addr, ls_eff_addr, sel_addr;
  logic [1:0]            if_eff_len, ls_eff_len, sel_len;
  logic [DATA_WIDTH-1:0] if_eff_wdata, ls_eff_wdata, sel_wdata;
  logic                  unused_if_wr_flag;

  // Fetch never writes; its write flag bit carries no meaning.
  assign unused_if_wr_flag = if_rw_flag[RW_WR_BIT];

  assign idle = (state == ST_IDLE);

  // A pulse while busy is illegal and dropped; a fetch pulse under clear is dropped.
  assign if_pulse = if_rw_flag[RW_RD_BIT] & ~if_busy & ~clear;
  assign ls_pulse = (|ls_rw_flag) & ~ls_busy;

  assign if_req = (if_slot_vld & ~clear) | if_pulse;
  assign ls_req = ls_slot_vld | ls_pulse;

  // Pending slot takes precedence; otherwise bypass the live pulse.
  assign if_eff_wr    = if_slot_vld ? if_slot_wr    : 1'b0;
  assign if_eff_addr  = if_slot_vld ? if_slot_addr  : if_addr;
  assign if_eff_len   = if_slot_vld ? if_slot_len   : if_len;
  assign if_eff_wdata = if_slot_vld ? if_slot_wdata : '0;
  assign ls_eff_wr    = ls_slot_vld ? ls_slot_wr    : ls_rw_flag[RW_WR_BIT];
  assign ls_eff_addr  = ls_slot_vld ? ls_slot_addr  : ls_addr;
  assign ls_eff_len   = ls_slot_vld ? ls_slot_len   : ls_len;
  assign ls_eff_wdata = ls_slot_vld ? ls_slot_wdata : ls_wdata;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  // On contention the port not granted last time wins.
  assign grant_ls = ls_req & (~if_req | (last_grant == PORT_IF));

  // Remember which port won the most recent grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= PORT_IF;
    end else if (rdy && grant_go) begin
      last_grant <= grant_ls ? PORT_LS : PORT_IF;
    end
  end
`else
  assign grant_ls = ls_req;
`endif

  assign grant_if = if_req & ~grant_ls;
  assign grant_go = idle & (if_req | ls_req);

  assign sel_wr    = grant_ls ? ls_eff_wr    : if_eff_wr;
  assign sel_addr  = grant_ls ? ls_eff_addr  : if_eff_addr;
  assign sel_len   = grant_ls ? ls_eff_len   : if_eff_len;
  assign sel_wdata = grant_ls ? ls_eff_wdata : if_eff_wdata;

  // Pulses not granted on the spot are parked; a granted slot is popped.
  assign if_cap   = rdy & if_pulse & ~(idle & grant_if);
  assign ls_cap   = rdy & ls_pulse & ~(idle & grant_ls);
  assign if_pop   = rdy & idle & grant_if & if_slot_vld;
  assign ls_pop   = rdy & idle & grant_ls & ls_slot_vld;
  assign if_flush = rdy & clear;

  mem_arb_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_if_slot (
    .clk      (clk),
    .rst      (rst),
    .cap      (if_cap),
    .cap_wr   (1'b0),
    .cap_addr (if_addr),
    .cap_len  (if_len),
    .cap_wdata('0),
    .pop      (if_pop),
    .flush    (if_flush),
    .vld      (if_slot_vld),
    .wr       (if_slot_wr),
    .addr     (if_slot_addr),
    .len      (if_slot_len),
    .wdata    (if_slot_wdata)
  );

  mem_arb_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ls_slot (
    .clk      (clk),
    .rst      (rst),
    .cap      (ls_cap),
    .cap_wr   (ls_rw_flag[RW_WR_BIT]),
    .cap_addr (ls_addr),
    .cap_len  (ls_len),
    .cap_wdata(ls_wdata),
    .pop      (ls_pop),
    .flush    (1'b0),
    .vld      (ls_slot_vld),
    .wr       (ls_slot_wr),
    .addr     (ls_slot_addr),
    .len      (ls_slot_len),
    .wdata    (ls_slot_wdata)
  );

  assign if_busy = if_slot_vld | (~idle & (owner == PORT_IF));
  assign ls_busy = ls_slot_vld | (~idle & (owner == PORT_LS));

  // Byte beat k goes to base+k; address arithmetic wraps at the top of the space.
  assign ram_a    = idle ? '0 : (base + ADDR_WIDTH'(k));
  assign ram_dout = (state == ST_WRITE) ? get_lane(wdata, k) : 8'h00;
  assign ram_wr   = (state == ST_WRITE) & rdy;

  // Transaction sequencer: grant in IDLE, issue byte beats, assemble and return data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      owner    <= PORT_IF;
      base     <= '0;
      len      <= LEN_BYTE;
      wdata    <= '0;
      k        <= 2'd0;
      tail     <= 1'b0;
      rd_buf   <= '0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_rdata <= '0;
      ls_rdata <= '0;
    end else if (rdy) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_go) begin
            state  <= sel_wr ? ST_WRITE : ST_READ;
            owner  <= grant_ls ? PORT_LS : PORT_IF;
            base   <= sel_addr;
            len    <= sel_len;
            wdata  <= sel_wdata;
            k      <= 2'd0;
            tail   <= 1'b0;
            rd_buf <= '0;
          end
        end
        ST_READ: begin
          if (clear && (owner == PORT_IF)) begin
            // Flushed fetch: drop collected bytes, no completion.
            state <= ST_IDLE;
          end else if (tail) begin
            // Last byte arrives now; unused upper lanes stay zero.
            state <= ST_IDLE;
            if (owner == PORT_LS) begin
              ls_done  <= 1'b1;
              ls_rdata <= put_lane(rd_buf, len, ram_din);
            end else begin
              if_done  <= 1'b1;
              if_rdata <= put_lane(rd_buf, len, ram_din);
            end
          end else begin
            // ram_din carries the byte addressed one beat earlier.
            if (k != 2'd0) rd_buf <= put_lane(rd_buf, k - 2'd1, ram_din);
            if (k == len) tail <= 1'b1;
            else          k    <= k + 2'd1;
          end
        end
        ST_WRITE: begin
          if (k == len) begin
            state   <= ST_IDLE;
            ls_done <= 1'b1;
          end else begin
            k <= k + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A port may not issue a new request while its previous one is outstanding.
  always @(posedge clk) begin
    if (rst && rdy) begin
      assert (!(if_rw_flag[RW_RD_BIT] && if_busy))
        else $error("mem_arbiter: IF request while if_busy, ignored");
      assert (!((|ls_rw_flag) && ls_busy))
        else $error("mem_arbiter: LS request while ls_busy, ignored");
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of completions plus bus checks at fixed cycles.
// Latency: n/a.
// Backpressure: exercises rdy freeze, clear abort and async reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic [1:0]  if_rw_flag, ls_rw_flag;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [1:0]  if_len, ls_len;
  logic        if_busy, if_done, ls_busy, ls_done, ram_wr;
  logic [31:0] if_rdata, ls_rdata, ram_a;
  logic [7:0]  ram_din, ram_dout;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  pre [1024];
  int          cyc = 0;
  int          c0;
  int          n_assert = 0;
  int          n_fail = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_rw_flag(if_rw_flag), .if_addr(if_addr), .if_len(if_len),
    .if_busy(if_busy), .if_done(if_done), .if_rdata(if_rdata),
    .ls_rw_flag(ls_rw_flag), .ls_addr(ls_addr), .ls_len(ls_len), .ls_wdata(ls_wdata),
    .ls_busy(ls_busy), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read RAM that holds its output while rdy is low.
  always @(posedge clk) begin
    if (rdy) ram_din <= pre[ram_a[9:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_done(input logic is_ls, input logic [31:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      chk("spurious done", 64'(is_ls ? ls_done : if_done), 64'd0);
    end else begin
      e = sb.pop_front();
      chk("done port", 64'(is_ls), 64'(e.is_ls));
      chk("done data", 64'(d), 64'(e.data));
      chk("done cycle", 64'(cyc), 64'(e.at));
    end
  endtask

  // Completion monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (if_done) check_done(1'b0, if_rdata);
      if (ls_done) check_done(1'b1, ls_rdata);
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      go();
      n++;
    end
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) pre[i] = 8'h00;
    pre[10'h000] = 8'h13; pre[10'h001] = 8'h05;
    pre[10'h100] = 8'hCD; pre[10'h101] = 8'hAB;
    pre[10'h200] = 8'h11; pre[10'h201] = 8'h22; pre[10'h202] = 8'h33; pre[10'h203] = 8'h44;
    pre[10'h3FF] = 8'h7E;

    rst = 1'b0; rdy = 1'b1; clear = 1'b0;
    if_rw_flag = 2'b00; if_addr = '0; if_len = LEN_BYTE;
    ls_rw_flag = 2'b00; ls_addr = '0; ls_len = LEN_BYTE; ls_wdata = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("reset if_busy", if_busy, 0);
    chk("reset ls_busy", ls_busy, 0);
    chk("reset if_done", if_done, 0);
    chk("reset ls_done", ls_done, 0);
    chk("reset ram_wr", ram_wr, 0);
    chk("reset ram_a", ram_a, 0);
    chk("reset ram_dout", ram_dout, 0);
    chk("reset if_rdata", if_rdata, 0);
    chk("reset ls_rdata", ls_rdata, 0);
    go();
    rst = 1'b1;
    go(); go();

    // IF word read at 0x1000
    c0 = cyc;
    if_rw_flag = 2'b01; if_addr = 32'h1000; if_len = LEN_WORD;
    sb.push_back('{is_ls: 1'b0, data: 32'h00000513, at: c0 + 6});
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("t1 if_busy before capture", if_busy, 0);
      if (i == 1) chk("t1 if_busy after capture", if_busy, 1);
      if (i >= 1 && i <= 4) begin
        chk("t1 ram_a", ram_a, 64'(32'h1000 + i - 1));
        chk("t1 ram_wr", ram_wr, 0);
      end
      if (i == 6) chk("t1 if_busy at done", if_busy, 0);
      go();
      if_rw_flag = 2'b00;
    end
    drain(20);

    // LS byte write to 0x30004
    c0 = cyc;
    ls_rw_flag = 2'b10; ls_addr = 32'h30004; ls_len = LEN_BYTE; ls_wdata = 32'h000000AB;
    sb.push_back('{is_ls: 1'b1, data: 32'h0, at: c0 + 2});
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("t2 ram_wr beat", ram_wr, 1);
        chk("t2 ram_a beat", ram_a, 32'h30004);
        chk("t2 ram_dout beat", ram_dout, 8'hAB);
      end
      if (i == 2) begin
        chk("t2 ram_wr at done", ram_wr, 0);
        chk("t2 ls_busy at done", ls_busy, 0);
      end
      go();
      ls_rw_flag = 2'b00;
    end
    drain(20);

    // Simultaneous IF half read and LS word read
    c0 = cyc;
    if_rw_flag = 2'b01; if_addr = 32'h100; if_len = LEN_HALF;
    ls_rw_flag = 2'b01; ls_addr = 32'h200; ls_len = LEN_WORD;
`ifdef MEM_ARB_RR_EN
    sb.push_back('{is_ls: 1'b0, data: 32'h0000ABCD, at: c0 + 4});
    sb.push_back('{is_ls: 1'b1, data: 32'h44332211, at: c0 + 10});
`else
    sb.push_back('{is_ls: 1'b1, data: 32'h44332211, at: c0 + 6});
    sb.push_back('{is_ls: 1'b0, data: 32'h0000ABCD, at: c0 + 10});
`endif
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("t3 if_busy", if_busy, 1);
        chk("t3 ls_busy", ls_busy, 1);
`ifdef MEM_ARB_RR_EN
        chk("t3 first beat addr", ram_a, 32'h100);
`else
        chk("t3 first beat addr", ram_a, 32'h200);
`endif
      end
`ifndef MEM_ARB_RR_EN
      if (i == 7) chk("t3 IF beat after LS done", ram_a, 32'h100);
`endif
      go();
      if_rw_flag = 2'b00;
      ls_rw_flag = 2'b00;
    end
    drain(20);

    // clear aborts IF word read; pending LS half store proceeds
    c0 = cyc;
    if_rw_flag = 2'b01; if_addr = 32'h1000; if_len = LEN_WORD;
    ls_addr = 32'h40; ls_len = LEN_HALF; ls_wdata = 32'h0000BEEF;
    sb.push_back('{is_ls: 1'b1, data: 32'h44332211, at: c0 + 7});
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (i == 3) chk("t4 if_busy during clear", if_busy, 1);
      if (i == 4) begin
        chk("t4 if_busy after clear", if_busy, 0);
        chk("t4 ram_wr idle", ram_wr, 0);
        chk("t4 ls_busy pending", ls_busy, 1);
      end
      if (i == 5) begin
        chk("t4 ram_wr beat0", ram_wr, 1);
        chk("t4 ram_a beat0", ram_a, 32'h40);
        chk("t4 ram_dout beat0", ram_dout, 8'hEF);
      end
      if (i == 6) begin
        chk("t4 ram_a beat1", ram_a, 32'h41);
        chk("t4 ram_dout beat1", ram_dout, 8'hBE);
      end
      go();
      if_rw_flag = 2'b00;
      ls_rw_flag = (i == 0) ? 2'b10 : 2'b00;
      clear = (i == 2);
    end
    drain(20);

    // rdy low in cycles 2..4 of LS half read across the address wrap
    c0 = cyc;
    ls_rw_flag = 2'b01; ls_addr = 32'hFFFFFFFF; ls_len = LEN_HALF;
    sb.push_back('{is_ls: 1'b1, data: 32'h0000137E, at: c0 + 7});
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) chk("t5 ram_a byte0", ram_a, 32'hFFFFFFFF);
      if (i == 2) chk("t5 ram_a wrapped", ram_a, 32'h0);
      if (i == 4) begin
        chk("t5 ram_a frozen", ram_a, 32'h0);
        chk("t5 ls_busy frozen", ls_busy, 1);
      end
      if (i == 5) chk("t5 ram_a resumed", ram_a, 32'h0);
      go();
      ls_rw_flag = 2'b00;
      rdy = !(i >= 1 && i <= 3);
    end
    rdy = 1'b1;
    drain(20);

    // Async reset in the middle of an LS word write
    c0 = cyc;
    ls_rw_flag = 2'b10; ls_addr = 32'h80; ls_len = LEN_WORD; ls_wdata = 32'hDEADBEEF;
    @(negedge clk);
    go();
    ls_rw_flag = 2'b00;
    @(negedge clk);
    chk("t6 ram_wr before reset", ram_wr, 1);
    chk("t6 ram_dout before reset", ram_dout, 8'hEF);
    go();
    #2;
    rst = 1'b0;
    #1;
    chk("t6 ram_wr in reset", ram_wr, 0);
    chk("t6 ram_a in reset", ram_a, 0);
    chk("t6 ls_busy in reset", ls_busy, 0);
    chk("t6 ls_rdata in reset", ls_rdata, 0);
    chk("t6 if_rdata in reset", if_rdata, 0);
    go(); go();
    rst = 1'b1;
    repeat (8) go();
    chk("final scoreboard empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
